fifo_uart_tx: RTL

Drain-side consumer of the synchronous FIFO. It pops bytes from the FIFO read port (data_out / empty_out / read_en_in) and serializes each one as an asynchronous UART frame on a single line: 1 start bit, DATA_WIDTH data bits LSB-first, 1 stop bit. It sits between the CPU-side TX FIFO and the board TX pin, and is the transmit counterpart to the FIFO write path driven by the core.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/fifo_uart_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
// UART_TX_PARITY_EN adds the PARITY state to the transmit FSM encoding.
package uart_pkg;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    STOP   = 3'd5
`ifdef UART_TX_PARITY_EN
    ,
    PARITY = 3'd6
`endif
  } tx_state_t;

  function automatic int baud_cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Per-bit baud counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_done on the last count of each bit period. Shared with the RX side.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_done = en && !clear && (cnt == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and sends each as an 8N1-style UART frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_empty_in,
  output logic                  fifo_read_en_out,
  output logic                  tx_out,
  output logic                  busy_out
);

  localparam int BIT_CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BIT_CW-1:0]     bit_cnt;
  logic                  baud_en;
  logic                  bit_done;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  // The baud counter only runs while a bit is on the line; it is held at zero
  // through IDLE, POP and LOAD so every frame starts on a fresh bit period.
  always_comb begin
    baud_en = 1'b0;
    case (state)
      START, DATA, STOP: baud_en = 1'b1;
`ifdef UART_TX_PARITY_EN
      PARITY:            baud_en = 1'b1;
`endif
      default:           baud_en = 1'b0;
    endcase
  end

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (baud_en),
    .clear    (!baud_en),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      fifo_read_en_out <= 1'b0;
      tx_out           <= IDLE_LEVEL;
      busy_out         <= 1'b0;
      bit_cnt          <= '0;
      shift_reg        <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit       <= 1'b0;
`endif
    end else begin
      fifo_read_en_out <= 1'b0;

      // The line is a registered copy of the current state, so it trails the
      // state by one cycle; this places the start bit three edges after the pop decision.
      case (state)
        START:   tx_out <= ~IDLE_LEVEL;
        DATA:    tx_out <= shift_reg[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  tx_out <= parity_bit;
`endif
        default: tx_out <= IDLE_LEVEL;
      endcase

      case (state)
        IDLE: begin
          if (!fifo_empty_in) begin
            state            <= POP;
            fifo_read_en_out <= 1'b1;
            busy_out         <= 1'b1;
          end
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          shift_reg <= fifo_data_in;
`ifdef UART_TX_PARITY_EN
          parity_bit <= ^fifo_data_in;
`endif
          state     <= START;
        end
        START: begin
          if (bit_done) begin
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
